arb_req_ctrl: RTL
=================

# arb_req_ctrl

Requester-side controller for the 4-channel fixed-priority grant logic. It collects transaction requests from four clients and presents a registered request vector to the arbiter. It accepts the arbiter's one-hot grant, runs a fixed-length burst for the granted channel, then releases the bus. It holds ownership stable during a burst, because the fixed-priority arbiter would otherwise re-grant as soon as a higher-priority request rose.

## Interface
Parameters:
- BURST_LEN, 4, beats per granted transaction (1..16)
- PEND_W, 3, width of each per-channel pending counter; max pending = 2^PEND_W-1

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low
- enable  in  1  high allows new requests; low stops new requests
- push  in  4  per-channel one-cycle pulse, posts one pending transaction
- gnt  in  4  one-hot grant from arbiter, combinational from req
- req  out  4  registered request vector to arbiter
- beat_valid  out  1  high during each burst beat
- beat_ch  out  2  index of the owning channel, valid with beat_valid
- beat_last  out  1  final beat of the burst
- busy  out  1  state is not IDLE
- pend_full  out  4  pending counter of that channel at max
- overflow  out  4  sticky; push arrived while the channel was full
- gnt_err  out  1  sticky; gnt not one-hot, or not a subset of req, while in REQ

## Operation
- States: IDLE, REQ, BURST, REL.
- IDLE
  - If enable and any pending[i]!=0: go to REQ and load req with the nonzero-pending mask.
  - Otherwise req=0.
- REQ
  - Each cycle, req <= nonzero-pending mask.
  - If enable drops: go to IDLE with req=0.
  - If gnt is one-hot and gnt&req!=0: latch owner=index(gnt), go to BURST, req <= one-hot(owner) only.
  - gnt==0: stay in REQ.
  - Invalid gnt: stay in REQ and set gnt_err.
- BURST
  - beat_valid=1 and beat_ch=owner for BURST_LEN cycles.
  - beat_cnt runs 0..BURST_LEN-1; beat_last is asserted when beat_cnt==BURST_LEN-1.
  - gnt is ignored.
  - enable low does not abort the burst.
  - On the last beat, pending[owner] decrements and the state goes to REL.
- REL
  - req=0 for one cycle.
  - Then go to REQ if enable and any pending; otherwise go to IDLE.
- Pending counters
  - push with counter not full: increment.
  - push while full: ignored, overflow[i] set.
  - Push and decrement on the same channel in the same cycle: count unchanged.
  - Pushes are accepted in every state.
- Reset low (any state, including mid-burst), on the next edge:
  - state=IDLE
  - all counters, req, beat_valid, beat_ch, beat_last, busy, pend_full, overflow, gnt_err = 0.

## Timing
- push sampled at edge k: pending updates after edge k; req asserted after edge k+1 (state REQ).
- A valid gnt in REQ cycle c produces the first beat in cycle c+1.
- A burst occupies exactly BURST_LEN consecutive cycles.
- Last beat in cycle L: REL in L+1 (req=0); earliest next req in L+2.
- All outputs are registered except beat_last, which is decoded from the registered beat_cnt and state.
- During BURST, req equals one-hot(owner) so a fixed-priority arbiter keeps gnt stable.

## Structure
- Package arb_pkg:
  - NCH=4
  - state enum {IDLE, REQ, BURST, REL}
  - onehot-to-index function
  - is_onehot function
- Sub-module pend_counter: a saturating up/down counter of PEND_W bits with inc, dec, full, nz and ovf_set outputs, instantiated NCH times.

## Test plan
- Reset low for 2 cycles with push=1111: all outputs 0, no req afterwards while no pushes.
- push=0100 pulse, fixed-priority arbiter model on gnt: req=0100 two cycles later, then 4 beats with beat_ch=2 and beat_last on the 4th; REL with req=0; then IDLE.
- push=0101 in one cycle: ch0 burst first with req=0001 throughout, REL, then req=0100 and ch2 burst.
- PEND_W=3, 8 back-to-back push[1] pulses with enable=0: pend_full[1]=1 after the 7th, overflow[1]=1 after the 8th; after enable rises, exactly 7 ch1 bursts.
- enable dropped on beat 2 of a ch3 burst with ch3 still pending: burst completes all 4 beats, then IDLE with req=0.
- Two edge cases:
  - reset low on beat 2: next cycle beat_valid=0, req=0, pending cleared.
  - gnt forced to 0011 with req=0011: gnt_err=1 and state stays REQ.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the requester-side arbitration controller.
package arb_pkg;

  localparam int NCH  = 4;
  localparam int CH_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    BURST = 2'd2,
    REL   = 2'd3
  } state_t;

  // Index of the highest set bit; only meaningful for one-hot input.
  function automatic logic [CH_W-1:0] onehot_to_idx(input logic [NCH-1:0] v);
    logic [CH_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (v[i]) idx = CH_W'(i);
    end
    return idx;
  endfunction

  // True when exactly one bit is set.
  function automatic logic is_onehot(input logic [NCH-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < NCH; i++) begin
      if (v[i]) n++;
    end
    return (n == 1);
  endfunction

endpackage

// File: rtl/arb_req_ctrl_if.sv
// Client/arbiter-facing signal bundle of the requester controller.
interface arb_req_ctrl_if;
  import arb_pkg::*;

  logic            enable;
  logic [NCH-1:0]  push;
  logic [NCH-1:0]  gnt;
  logic [NCH-1:0]  req;
  logic            beat_valid;
  logic [CH_W-1:0] beat_ch;
  logic            beat_last;
  logic            busy;
  logic [NCH-1:0]  pend_full;
  logic [NCH-1:0]  overflow;
  logic            gnt_err;

  modport master (
    input  enable, push, gnt,
    output req, beat_valid, beat_ch, beat_last, busy, pend_full, overflow, gnt_err
  );

  modport slave (
    output enable, push, gnt,
    input  req, beat_valid, beat_ch, beat_last, busy, pend_full, overflow, gnt_err
  );

endinterface

// File: rtl/arb_req_ctrl_pend_counter.sv
// Saturating per-channel pending-transaction counter with registered flags.
module pend_counter #(
  parameter int PEND_W = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic nz,
  output logic ovf_set
);

  localparam logic [PEND_W-1:0] MAX = '1;

  logic [PEND_W-1:0] count_reg, count_next;
  logic              full_reg, nz_reg;

  // Simultaneous inc and dec cancel; inc saturates at MAX, dec stops at zero.
  always_comb begin
    count_next = count_reg;
    if (inc && dec) begin
      count_next = count_reg;
    end else if (inc && !full_reg) begin
      count_next = count_reg + 1'b1;
    end else if (dec && nz_reg) begin
      count_next = count_reg - 1'b1;
    end
  end

  // Count plus registered full/non-zero flags derived from the next count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_reg <= '0;
      full_reg  <= 1'b0;
      nz_reg    <= 1'b0;
    end else begin
      count_reg <= count_next;
      full_reg  <= (count_next == MAX);
      nz_reg    <= (count_next != '0);
    end
  end

  assign full    = full_reg;
  assign nz      = nz_reg;
  // A push that coincides with a decrement takes the freed slot, so no overflow.
  assign ovf_set = inc && full_reg && !dec;

endmodule

// File: rtl/arb_req_ctrl.sv
// Requester controller: pending counters, registered request vector,
// fixed-length burst for the granted channel, one-cycle release.
module arb_req_ctrl
  import arb_pkg::*;
#(
  parameter int BURST_LEN = 4,
  parameter int PEND_W    = 3
) (
  input logic            clk,
  input logic            reset,
  arb_req_ctrl_if.master bus
);

  localparam logic [3:0] LAST_BEAT = 4'(BURST_LEN - 1);

  state_t          state_reg, state_next;
  logic [NCH-1:0]  req_reg, req_next;
  logic [CH_W-1:0] owner_reg, owner_next;
  logic [3:0]      beat_cnt_reg, beat_cnt_next;
  logic            gnt_err_reg, gnt_err_next;
  logic            beat_valid_reg, busy_reg;
  logic [NCH-1:0]  overflow_reg;

  logic [NCH-1:0]  nz, full, ovf_set, dec;
  logic            last_beat;

  assign last_beat = (state_reg == BURST) && (beat_cnt_reg == LAST_BEAT);

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_pend
      assign dec[gi] = last_beat && (owner_reg == CH_W'(gi));
      pend_counter #(.PEND_W(PEND_W)) u_pend (
        .clk     (clk),
        .reset   (reset),
        .inc     (bus.push[gi]),
        .dec     (dec[gi]),
        .full    (full[gi]),
        .nz      (nz[gi]),
        .ovf_set (ovf_set[gi])
      );
    end
  endgenerate

  // Next state, request vector, owner and beat counter.
  always_comb begin
    state_next    = state_reg;
    req_next      = req_reg;
    owner_next    = owner_reg;
    beat_cnt_next = beat_cnt_reg;
    gnt_err_next  = gnt_err_reg;
    case (state_reg)
      IDLE: begin
        req_next = '0;
        if (bus.enable && (nz != '0)) begin
          state_next = REQ;
          req_next   = nz;
        end
      end
      REQ: begin
        req_next = nz;
        if (!bus.enable) begin
          state_next = IDLE;
          req_next   = '0;
        end else if (is_onehot(bus.gnt) && ((bus.gnt & req_reg) != '0)) begin
          // Narrow the request to the owner so the arbiter cannot re-grant.
          state_next    = BURST;
          owner_next    = onehot_to_idx(bus.gnt);
          req_next      = bus.gnt;
          beat_cnt_next = '0;
        end else if (bus.gnt != '0) begin
          gnt_err_next = 1'b1;
        end
      end
      BURST: begin
        if (beat_cnt_reg == LAST_BEAT) begin
          state_next    = REL;
          req_next      = '0;
          beat_cnt_next = '0;
        end else begin
          beat_cnt_next = beat_cnt_reg + 1'b1;
        end
      end
      REL: begin
        req_next = '0;
        if (bus.enable && (nz != '0)) begin
          state_next = REQ;
          req_next   = nz;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        req_next   = '0;
      end
    endcase
  end

  // State and registered outputs; beat_valid/busy follow the next state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= IDLE;
      req_reg        <= '0;
      owner_reg      <= '0;
      beat_cnt_reg   <= '0;
      gnt_err_reg    <= 1'b0;
      beat_valid_reg <= 1'b0;
      busy_reg       <= 1'b0;
      overflow_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      req_reg        <= req_next;
      owner_reg      <= owner_next;
      beat_cnt_reg   <= beat_cnt_next;
      gnt_err_reg    <= gnt_err_next;
      beat_valid_reg <= (state_next == BURST);
      busy_reg       <= (state_next != IDLE);
      overflow_reg   <= overflow_reg | ovf_set;
    end
  end

  assign bus.req        = req_reg;
  assign bus.beat_valid = beat_valid_reg;
  assign bus.beat_ch    = owner_reg;
  assign bus.beat_last  = last_beat;
  assign bus.busy       = busy_reg;
  assign bus.pend_full  = full;
  assign bus.overflow   = overflow_reg;
  assign bus.gnt_err    = gnt_err_reg;

endmodule
